// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: transmit-sequencer state encoding and bus constants.
package i2c_pkg;

    localparam int I2C_BYTE_BITS = 8;
    localparam logic SDA_RELEASE = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_SHIFT    = 3'd1,
        TX_ACK_WAIT = 3'd2,
        TX_ACK_HOLD = 3'd3,
        TX_STRETCH  = 3'd4
    } i2c_tx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Parameterised up-counter with synchronous clear; holds at rollover_val instead of wrapping.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_reg;
    logic [NUM_CNT_BITS-1:0] count_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Clear wins over enable so a load in the same cycle as a stray edge starts from zero.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_enable && (count_reg != rollover_val)) begin
            count_next = count_reg + 1'b1;
        end
    end

    assign count_out     = count_reg;
    assign rollover_flag = (count_reg == rollover_val);

endmodule

// File: rtl/i2c_tx_timer.sv
// Slave-side I2C transmit sequencer: shifts a byte out MSB-first, then samples the master's ACK.
// Define I2C_TX_CLOCK_STRETCH_EN to add tx_valid/scl_hold clock stretching when the next byte is late.
module i2c_tx_timer
    import i2c_pkg::*;
#(
    parameter int BYTE_BITS = I2C_BYTE_BITS,
    parameter int CNT_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rising_edge_found,
    input  logic                 falling_edge_found,
    input  logic                 start_found,
    input  logic                 stop_found,
    input  logic                 tx_load,
    input  logic [BYTE_BITS-1:0] tx_data,
    input  logic                 sda_in,
`ifdef I2C_TX_CLOCK_STRETCH_EN
    input  logic                 tx_valid,
    output logic                 scl_hold,
`endif
    output logic                 sda_out,
    output logic                 tx_busy,
    output logic                 byte_sent,
    output logic                 load_next,
    output logic                 ack_received,
    output logic                 nack_received
);

    i2c_tx_state_t        state_reg;
    i2c_tx_state_t        state_next;
    logic [BYTE_BITS-1:0] shift_reg;
    logic [BYTE_BITS-1:0] shift_next;

    logic                 rise;
    logic                 fall;
    logic                 abort;
    logic                 data_ready;
    logic                 cnt_clear;
    logic                 cnt_enable;
    logic                 byte_done;
    logic [CNT_BITS-1:0]  bit_count;
    logic                 bit_count_unused;

    // Coincident edge pulses carry no usable SCL information, so both are dropped.
    assign rise  = rising_edge_found & ~falling_edge_found;
    assign fall  = falling_edge_found & ~rising_edge_found;
    assign abort = (start_found | stop_found) & (state_reg != TX_IDLE);

`ifdef I2C_TX_CLOCK_STRETCH_EN
    assign data_ready = tx_valid;
    assign scl_hold   = (state_reg == TX_STRETCH);
`else
    assign data_ready = 1'b1;
`endif

    assign cnt_enable = rise & (state_reg == TX_SHIFT) & ~abort;

    flex_counter #(
        .NUM_CNT_BITS(CNT_BITS)
    ) u_bit_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clear),
        .count_enable (cnt_enable),
        .rollover_val (CNT_BITS'(BYTE_BITS)),
        .count_out    (bit_count),
        .rollover_flag(byte_done)
    );

    assign bit_count_unused = ^bit_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= TX_IDLE;
            shift_reg <= '1;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        cnt_clear     = 1'b0;
        byte_sent     = 1'b0;
        load_next     = 1'b0;
        ack_received  = 1'b0;
        nack_received = 1'b0;
        if (abort) begin
            state_next = TX_IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state_reg)
                TX_IDLE: begin
                    if (tx_load) begin
                        shift_next = tx_data;
                        cnt_clear  = 1'b1;
                        state_next = TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (fall) begin
                        if (byte_done) begin
                            byte_sent  = 1'b1;
                            state_next = TX_ACK_WAIT;
                        end else begin
                            shift_next = {shift_reg[BYTE_BITS-2:0], 1'b1};
                        end
                    end
                end
                TX_ACK_WAIT: begin
                    if (rise) begin
                        if (!sda_in) begin
                            ack_received = 1'b1;
                            load_next    = 1'b1;
                            state_next   = TX_ACK_HOLD;
                        end else begin
                            nack_received = 1'b1;
                            state_next    = TX_IDLE;
                        end
                    end
                end
                TX_ACK_HOLD: begin
                    if (fall) begin
                        if (data_ready) begin
                            shift_next = tx_data;
                            cnt_clear  = 1'b1;
                            state_next = TX_SHIFT;
                        end else begin
                            state_next = TX_STRETCH;
                        end
                    end
                end
                TX_STRETCH: begin
                    // SCL is held low here, so only the late data (or an abort) moves us on.
                    if (data_ready) begin
                        shift_next = tx_data;
                        cnt_clear  = 1'b1;
                        state_next = TX_SHIFT;
                    end
                end
                default: begin
                    state_next = TX_IDLE;
                end
            endcase
        end
    end

    assign tx_busy = (state_reg != TX_IDLE);
    assign sda_out = (state_reg == TX_SHIFT) ? shift_reg[BYTE_BITS-1] : SDA_RELEASE;

endmodule

// File: tb/tb_i2c_tx_timer.sv
// Self-checking bench for i2c_tx_timer: randomized byte chains checked against a bit-level reference model.
module tb_i2c_tx_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rising_edge_found = 1'b0;
    logic       falling_edge_found = 1'b0;
    logic       start_found = 1'b0;
    logic       stop_found = 1'b0;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_in = 1'b1;
    logic       sda_out;
    logic       tx_busy;
    logic       byte_sent;
    logic       load_next;
    logic       ack_received;
    logic       nack_received;
`ifdef I2C_TX_CLOCK_STRETCH_EN
    logic       tx_valid = 1'b1;
    logic       scl_hold;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_bs = 0, cnt_ln = 0, cnt_ack = 0, cnt_nack = 0;
    int exp_bs = 0, exp_ln = 0, exp_ack = 0, exp_nack = 0;

    i2c_tx_timer dut (
        .clk               (clk),
        .rst               (rst),
        .rising_edge_found (rising_edge_found),
        .falling_edge_found(falling_edge_found),
        .start_found       (start_found),
        .stop_found        (stop_found),
        .tx_load           (tx_load),
        .tx_data           (tx_data),
        .sda_in            (sda_in),
`ifdef I2C_TX_CLOCK_STRETCH_EN
        .tx_valid          (tx_valid),
        .scl_hold          (scl_hold),
`endif
        .sda_out           (sda_out),
        .tx_busy           (tx_busy),
        .byte_sent         (byte_sent),
        .load_next         (load_next),
        .ack_received      (ack_received),
        .nack_received     (nack_received)
    );

    always #5 clk = ~clk;

    // Observed pulse totals, compared against the model's totals at the end.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            cnt_bs   += int'(byte_sent);
            cnt_ln   += int'(load_next);
            cnt_ack  += int'(ack_received);
            cnt_nack += int'(nack_received);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rising_edge_found  = 1'b0;
        falling_edge_found = 1'b0;
        start_found        = 1'b0;
        stop_found         = 1'b0;
        tx_load            = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick();
    endtask

    // Clock out nbits of d; expected bit i is simply bit (7-i) of the byte.
    task automatic run_byte(input logic [7:0] d, input int nbits, input bit noise, input string tag);
        for (int i = 0; i < nbits; i++) begin
            logic exp_bit;
            exp_bit = d[7-i];
            n_cmp++;
            if (sda_out !== exp_bit) begin
                n_bad++;
                $display("FAIL %s bit%0d: sda_out=%b required %b", tag, i, sda_out, exp_bit);
            end
            if (noise) begin
                rising_edge_found  = 1'b1;
                falling_edge_found = 1'b1;
                tx_load            = 1'b1;
                tx_data            = ~d;
                tick();
            end
            repeat ($urandom_range(0, 2)) tick();
            n_cmp++;
            if (sda_out !== exp_bit) begin
                n_bad++;
                $display("FAIL %s hold%0d: sda_out=%b required %b", tag, i, sda_out, exp_bit);
            end
            sda_in = 1'b1;
            rising_edge_found = 1'b1;
            tick();
            if (noise && i == 7) begin
                repeat (9) begin
                    rising_edge_found = 1'b1;
                    tick();
                end
            end
            repeat ($urandom_range(0, 2)) tick();
            falling_edge_found = 1'b1;
            #1;
            n_cmp++;
            if (byte_sent !== (i == 7)) begin
                n_bad++;
                $display("FAIL %s byte_sent@%0d: got %b required %b", tag, i, byte_sent, (i == 7));
            end
            if (i == 7) exp_bs++;
            tick();
        end
        if (nbits == 8) begin
            n_cmp++;
            if (sda_out !== 1'b1 || tx_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s ack_slot_release: sda_out=%b busy=%b required 1 1", tag, sda_out, tx_busy);
            end
        end
    endtask

    task automatic ack_slot(input bit ack, input logic [7:0] next, input string tag);
        sda_in = ack ? 1'b0 : 1'b1;
        rising_edge_found = 1'b1;
        #1;
        n_cmp++;
        if ({ack_received, load_next, nack_received} !== {ack, ack, ~ack}) begin
            n_bad++;
            $display("FAIL %s ack_pulses: ack/ln/nack=%b%b%b required %b%b%b", tag,
                     ack_received, load_next, nack_received, ack, ack, ~ack);
        end
        if (ack) begin
            exp_ack++;
            exp_ln++;
        end else begin
            exp_nack++;
        end
        tick();
        if (!ack) begin
            n_cmp++;
            if (tx_busy !== 1'b0 || sda_out !== 1'b1) begin
                n_bad++;
                $display("FAIL %s after_nack: busy=%b sda_out=%b required 0 1", tag, tx_busy, sda_out);
            end
        end else begin
            repeat ($urandom_range(0, 2)) tick();
            n_cmp++;
            if (sda_out !== 1'b1 || tx_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s ack_hold: sda_out=%b busy=%b required 1 1", tag, sda_out, tx_busy);
            end
            tx_data = next;
            falling_edge_found = 1'b1;
            tick();
            sda_in = 1'b1;
        end
        $display("xfer %s ack=%0d next=%02h", tag, ack, next);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({sda_out, tx_busy, byte_sent, load_next, ack_received, nack_received} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_state: outputs=%b required 100000",
                     {sda_out, tx_busy, byte_sent, load_next, ack_received, nack_received});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (tx_busy !== 1'b0 || sda_out !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy=%b sda_out=%b required 0 1", tx_busy, sda_out);
        end
    endtask

    task automatic test_single_nack();
        load_byte(8'hA5);
        run_byte(8'hA5, 8, 1'b0, "a5");
        ack_slot(1'b0, 8'h00, "a5_nack");
    endtask

    task automatic test_ack_chain();
        load_byte(8'hA5);
        run_byte(8'hA5, 8, 1'b0, "chain_a5");
        ack_slot(1'b1, 8'h3C, "chain_a5");
        run_byte(8'h3C, 8, 1'b0, "chain_3c");
        ack_slot(1'b0, 8'h00, "chain_3c");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [7:0] q[$];
            int n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            load_byte(q[0]);
            for (int k = 0; k < n; k++) begin
                run_byte(q[k], 8, 1'b0, "rand");
                ack_slot(k < n - 1, (k < n - 1) ? q[k+1] : 8'h00, "rand");
            end
        end
    endtask

    // Coincident edges, a stray tx_load and extra rising edges must not disturb the byte.
    task automatic test_noise();
        load_byte(8'hC3);
        run_byte(8'hC3, 8, 1'b1, "noise_c3");
        ack_slot(1'b0, 8'h00, "noise_c3");
    endtask

    task automatic test_stop_abort();
        load_byte(8'h00);
        run_byte(8'h00, 4, 1'b0, "stop_00");
        stop_found = 1'b1;
        rising_edge_found = 1'b1;
        #1;
        n_cmp++;
        if ({byte_sent, load_next, ack_received, nack_received} !== 4'b0000) begin
            n_bad++;
            $display("FAIL stop_no_pulse: pulses=%b required 0000",
                     {byte_sent, load_next, ack_received, nack_received});
        end
        tick();
        n_cmp++;
        if (sda_out !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_release: sda_out=%b busy=%b required 1 0", sda_out, tx_busy);
        end
        for (int k = 0; k < 12; k++) begin
            sda_in = 1'($urandom);
            if (k % 2 == 0) rising_edge_found = 1'b1;
            else falling_edge_found = 1'b1;
            tick();
        end
        sda_in = 1'b1;
        n_cmp++;
        if (tx_busy !== 1'b0 || sda_out !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_stays_idle: busy=%b sda_out=%b required 0 1", tx_busy, sda_out);
        end
    endtask

    task automatic test_start_in_ack();
        load_byte(8'h81);
        run_byte(8'h81, 8, 1'b0, "start_81");
        sda_in = 1'b0;
        start_found = 1'b1;
        rising_edge_found = 1'b1;
        #1;
        n_cmp++;
        if ({ack_received, load_next, nack_received} !== 3'b000) begin
            n_bad++;
            $display("FAIL start_priority: ack/ln/nack=%b required 000",
                     {ack_received, load_next, nack_received});
        end
        tick();
        sda_in = 1'b1;
        n_cmp++;
        if (tx_busy !== 1'b0 || sda_out !== 1'b1) begin
            n_bad++;
            $display("FAIL start_release: busy=%b sda_out=%b required 0 1", tx_busy, sda_out);
        end
    endtask

    task automatic test_async_reset();
        load_byte(8'h00);
        run_byte(8'h00, 2, 1'b0, "rst_00");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sda_out !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: sda_out=%b busy=%b required 1 0", sda_out, tx_busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        load_byte(8'hFF);
        run_byte(8'hFF, 8, 1'b0, "rst_ff");
        ack_slot(1'b0, 8'h00, "rst_ff");
    endtask

`ifdef I2C_TX_CLOCK_STRETCH_EN
    task automatic test_stretch();
        int hold_bad;
        hold_bad = 0;
        load_byte(8'hA5);
        run_byte(8'hA5, 8, 1'b0, "stretch_a5");
        sda_in = 1'b0;
        rising_edge_found = 1'b1;
        #1;
        n_cmp++;
        if (ack_received !== 1'b1 || load_next !== 1'b1) begin
            n_bad++;
            $display("FAIL stretch_ack: ack=%b ln=%b required 1 1", ack_received, load_next);
        end
        exp_ack++;
        exp_ln++;
        tick();
        tx_valid = 1'b0;
        falling_edge_found = 1'b1;
        tick();
        sda_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (scl_hold !== 1'b1 || sda_out !== 1'b1) hold_bad++;
            tick();
        end
        n_cmp++;
        if (hold_bad != 0) begin
            n_bad++;
            $display("FAIL stretch_hold: %0d cycles without scl_hold=1/sda_out=1, required 0", hold_bad);
        end
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        tick();
        n_cmp++;
        if (scl_hold !== 1'b0 || sda_out !== 1'b0) begin
            n_bad++;
            $display("FAIL stretch_release: scl_hold=%b sda_out=%b required 0 0", scl_hold, sda_out);
        end
        run_byte(8'h5A, 8, 1'b0, "stretch_5a");
        ack_slot(1'b0, 8'h00, "stretch_5a");
    endtask
`endif

    task automatic test_totals();
        tick();
        n_cmp++;
        if (cnt_bs !== exp_bs || cnt_ln !== exp_ln || cnt_ack !== exp_ack || cnt_nack !== exp_nack) begin
            n_bad++;
            $display("FAIL pulse_totals: bs/ln/ack/nack=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                     cnt_bs, cnt_ln, cnt_ack, cnt_nack, exp_bs, exp_ln, exp_ack, exp_nack);
        end
    endtask

    initial begin
        test_reset();
        test_single_nack();
        test_ack_chain();
        test_random();
        test_noise();
        test_stop_abort();
        test_start_in_ack();
        test_async_reset();
`ifdef I2C_TX_CLOCK_STRETCH_EN
        test_stretch();
`endif
        test_totals();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_tx_timer.md
Name: i2c_tx_timer

Overview:
- Slave-side I2C transmit sequencer: the transmitter counterpart of the slave receive timer.
- Serialises one byte MSB-first onto SDA while SCL is low, then releases SDA for the master's ACK bit and samples ACK/NACK on the SCL rising edge.
- On ACK, requests and loads the next byte; on NACK, STOP or START, it releases the bus.
- Sits beside the receive timer and consumes the same edge/start/stop detector pulses.

Parameters:
- BYTE_BITS, 8, data bits per byte before the ACK slot.
- CNT_BITS, 4, bit-counter width; must satisfy 2^CNT_BITS > BYTE_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rising_edge_found  in  1  one-cycle pulse, SCL rose
- falling_edge_found  in  1  one-cycle pulse, SCL fell
- start_found  in  1  one-cycle pulse, START/repeated START
- stop_found  in  1  one-cycle pulse, STOP
- tx_load  in  1  one-cycle pulse, begin read transfer (issued while SCL is low, after the address ACK)
- tx_data  in  BYTE_BITS  byte to send; sampled at load points
- sda_in  in  1  synchronised SDA line value
- sda_out  out  1  open-drain drive; 1 = release, 0 = pull low
- tx_busy  out  1  high in any state except IDLE
- byte_sent  out  1  one-cycle pulse, last data bit finished
- load_next  out  1  one-cycle pulse, master ACKed; tx_data must be valid by the next SCL falling edge
- ack_received  out  1  one-cycle pulse
- nack_received  out  1  one-cycle pulse

Behaviour:
- Clock and reset:
  - Single clk domain.
  - rst asserted: state=IDLE, shift register all ones, bit count 0, sda_out=1, all pulse outputs 0, tx_busy=0.
- States: IDLE, SHIFT, ACK_WAIT, ACK_HOLD (plus STRETCH when the optional feature is enabled).
- IDLE:
  - sda_out=1.
  - tx_load: shift_reg<=tx_data, count<=0, go to SHIFT.
  - bit7 appears on sda_out the cycle after tx_load.
- SHIFT:
  - sda_out=shift_reg[MSB].
  - rising_edge_found: count<=count+1.
  - falling_edge_found with count<BYTE_BITS: shift left, fill 1.
  - falling_edge_found with count==BYTE_BITS: go to ACK_WAIT; byte_sent=1 that cycle.
  - sda_out update latency after falling_edge_found: exactly 1 clk.
- ACK_WAIT:
  - sda_out=1.
  - rising_edge_found with sda_in==0: ack_received pulse, load_next pulse, go to ACK_HOLD.
  - rising_edge_found with sda_in==1: nack_received pulse, go to IDLE.
- ACK_HOLD:
  - sda_out=1 (master still drives ACK).
  - falling_edge_found: shift_reg<=tx_data, count<=0, go to SHIFT.
- Priority and abort rules:
  - start_found or stop_found in any non-IDLE state: go to IDLE, release SDA next cycle, no pulse outputs. This takes priority over edge pulses and over tx_load in the same cycle.
  - tx_load outside IDLE is ignored.
  - rising_edge_found and falling_edge_found in the same cycle: both ignored.
- Counter: count saturates at BYTE_BITS; extra rising edges in SHIFT never wrap.
- All pulse outputs are combinational decodes of registered state qualified by the input pulse; they are never high for more than 1 cycle.

Optional Feature:
- Macro I2C_TX_CLOCK_STRETCH_EN.
- When defined, adds input tx_valid (1) and output scl_hold (1, reset 0).
  - On falling_edge_found in ACK_HOLD with tx_valid=0: go to STRETCH and assert scl_hold=1 (slave holds SCL low).
  - In STRETCH: tx_valid=1 loads tx_data, sets count=0, deasserts scl_hold next cycle, and enters SHIFT.
  - start_found or stop_found in STRETCH aborts to IDLE.
- When undefined: no extra ports; tx_data is loaded unconditionally at the ACK_HOLD falling edge.

Decomposition:
- Package i2c_pkg:
  - tx state enum (i2c_tx_state_t, 3-bit);
  - BYTE_BITS default constant;
  - SDA_RELEASE=1'b1 constant.
- Sub-module: reuse flex_counter (NUM_CNT_BITS=CNT_BITS) as the bit counter.
  - count_enable = rising edge in SHIFT;
  - clear on load or abort;
  - rollover at BYTE_BITS, used as the byte-done flag.
- The shift register stays inline.

Test Plan:
- tx_load with tx_data=8'hA5, then 8 SCL pulses:
  - sda_out sequence 1,0,1,0,0,1,0,1, each bit stable from 1 clk after the falling edge;
  - byte_sent pulses at the 8th falling edge;
  - then sda_out=1.
- ACK path: sda_in=0 at the 9th rising edge:
  - ack_received and load_next pulse;
  - tx_data=8'h3C present at the next falling edge;
  - sda_out then shows 0,0,1,1,1,1,0,0.
- NACK path: sda_in=1 at the 9th rising edge:
  - nack_received pulse, state returns to IDLE, tx_busy=0, sda_out stays 1.
- stop_found after the 4th bit of 8'h00:
  - sda_out=1 next cycle, tx_busy=0;
  - later edges produce no pulses.
- rst asserted mid-byte while sda_out=0:
  - sda_out=1 and tx_busy=0 asynchronously;
  - subsequent tx_load of 8'hFF restarts cleanly from bit7.
- I2C_TX_CLOCK_STRETCH_EN defined, ACK with tx_valid=0 at the falling edge:
  - scl_hold=1 for the duration;
  - tx_valid raised 10 clks later: scl_hold=0 next cycle and bit7 of tx_data driven.
